matmul_calc_engine: RTL and testbench
=====================================

# matmul_calc_engine

Sequential, runtime-dimensioned signed matrix-multiply engine with a built-in multi-target result scratchpad. It computes C = A×B for any N×K by K×M up to MAX_DIM×MAX_DIM, one MAC per cycle, and writes results into one of SPNTARGETS scratchpad slots. In accumulate mode it computes C = C + A×B. It sits between the APB register file (operands, control) and the APB read path (results, flags).

## Interface
- DATA_WIDTH, 32, operand element width (signed)
- BUS_WIDTH, 64, result element width (signed)
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, maximum matrix dimension
- SPNTARGETS, 4, number of scratchpad result slots
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  start request; honoured only in IDLE
- dim_n_i, dim_k_i, dim_m_i  in  DIM_W each  dimension minus 1 (0 encodes 1)
- a_mat_i, b_mat_i  in  MAX_DIM·MAX_DIM·DATA_WIDTH  row-major flattened operands, element [r][c] at index r·MAX_DIM+c
- sp_sel_i  in  SP_W  destination slot
- accum_i  in  1  1 = add to the existing slot contents
- busy_o  out  1  high while computing
- done_o  out  1  one-cycle completion pulse
- ovf_o  out  MAX_DIM·MAX_DIM  per-element overflow flags of the last operation
- rd_sel_i, rd_row_i, rd_col_i  in  SP_W/DIM_W/DIM_W  result read address
- rd_data_o  out  BUS_WIDTH  registered read data

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE → CALC when start_i=1. At that edge, latch a_mat_i, b_mat_i, the dimensions, sp_sel_i and accum_i. Inputs may change afterwards.
- CALC walks row-major over i in 0..N-1 and j in 0..M-1, with inner loop k in 0..K-1. It performs one MAC per cycle.
- At k=0, the accumulator seeds from slot[sp_sel][i][j] if accum, else 0.
- At k=K-1, the final sum is written to slot[sp_sel][i][j]. Then k and j advance, wrapping j to i+1.
- After the last element (i=N-1, j=M-1, k=K-1), go to DONE. DONE → IDLE unconditionally after one cycle.
- Elements outside N×M and other slots are never written.
- Arithmetic:
  - Two's complement throughout.
  - Products are 2·DATA_WIDTH, sign-extended into a BUS_WIDTH+1 accumulator.
  - The stored result is the low BUS_WIDTH bits (wraps).
- ovf_o:
  - All bits clear at a start edge.
  - Bit i·MAX_DIM+j sets if any partial or final sum of element (i,j) is outside the signed BUS_WIDTH range.
  - Holds until the next start or reset.
- start_i in CALC or DONE is ignored. No queueing.
- Read port:
  - rd_data_o ← slot[rd_sel][rd_row][rd_col] every cycle.
  - On a same-cycle write to that address, it returns the pre-write value.
- Reset at any time, including mid-CALC:
  - State goes to IDLE; busy_o=0, done_o=0, ovf_o=0, rd_data_o=0.
  - All scratchpad entries are zeroed and counters cleared.

## Timing
- Start sampled at edge E0 → busy_o=1 for exactly N·K·M cycles following E0.
- done_o=1 for the single following cycle, with busy_o=0. Earliest next accepted start is the edge ending the DONE cycle +1.
- Result (i,j) is visible on rd_data_o two edges after its write edge: one for the write, one for the read register.
- Worst-case latency is MAX_DIM³ cycles + 1 DONE cycle.

## Configuration
- MATMUL_OVERFLOW_EN defined: overflow detection and ovf_o as specified.
- Not defined: no BUS_WIDTH+1 extension logic; ovf_o is tied to 0. Results wrap identically.

## Structure
- Shared package holds:
  - DATA_WIDTH, BUS_WIDTH, MAX_DIM, SPNTARGETS
  - DIM_W = max(1, $clog2(MAX_DIM)) and SP_W = max(1, $clog2(SPNTARGETS))
  - the FSM state enum
  - a typedef for the scratchpad slot (MAX_DIM×MAX_DIM×BUS_WIDTH)
- One sub-module: matmul_scratchpad. It holds the SPNTARGETS slots, with one write port, one combinational seed-read port for the engine, one registered read port, and a synchronous clear.
- The FSM, counters and MAC stay in the top.

## Test plan
- MAX_DIM=2, N=K=M=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], slot 0 → slot0=[[19,22],[43,50]]; busy 8 cycles then one done pulse; ovf_o=0.
- Repeat the same operands into slot 0 with accum=1 → slot0=[[38,44],[86,100]]; slots 1–3 remain 0.
- N=K=M=1, A[0][0]=0xFFFFFFFF (−1), B[0][0]=3, slot 3 → slot3[0][0]=0xFFFFFFFFFFFFFFFD; busy 1 cycle; other slot 3 elements untouched.
- N=M=1, K=2, A row=B column=0x80000000 → sum 2^63 stored as 0x8000000000000000.
  - With MATMUL_OVERFLOW_EN: ovf_o bit0=1.
  - Without it: ovf_o=0.
- Assert rst_i 3 cycles into an 8-cycle CALC → next cycle busy_o=0, ovf_o=0, all slots read 0. A fresh start then completes correctly.
- Pulse start_i again during CALC, with different operands → ignored. Results match the first operands, and exactly one done pulse is seen.

Source files
------------

// File: rtl/matmul_calc_engine_pkg.sv
// -----------------------------------------------------------------------------
// matmul_calc_engine_pkg
// Shared parameters, the engine FSM state type, the scratchpad slot type and a
// flattened-element index helper for the matrix-multiply engine.
// Optional feature macro used by the engine: MATMUL_OVERFLOW_EN.
// -----------------------------------------------------------------------------
package matmul_calc_engine_pkg;

    localparam int DATA_WIDTH = 32;                      // operand element width (signed)
    localparam int BUS_WIDTH  = 64;                      // result element width (signed)
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;  // maximum matrix dimension
    localparam int SPNTARGETS = 4;                       // number of result slots

    localparam int NUM_ELEMS = MAX_DIM * MAX_DIM;
    localparam int DIM_W     = (MAX_DIM > 1)    ? $clog2(MAX_DIM)    : 1;
    localparam int SP_W      = (SPNTARGETS > 1) ? $clog2(SPNTARGETS) : 1;
    localparam int IDX_W     = (NUM_ELEMS > 1)  ? $clog2(NUM_ELEMS)  : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One scratchpad slot: [row][col] of BUS_WIDTH-bit results.
    typedef logic [MAX_DIM-1:0][MAX_DIM-1:0][BUS_WIDTH-1:0] slot_t;

    // Row-major flattened element index: row*MAX_DIM + col.
    function automatic logic [IDX_W-1:0] elem_idx(input logic [DIM_W-1:0] row,
                                                  input logic [DIM_W-1:0] col);
        int t;
        t = int'(row) * MAX_DIM + int'(col);
        return t[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/matmul_calc_engine_if.sv
// -----------------------------------------------------------------------------
// matmul_calc_engine_if
// Bundles the control, operand, status and result-read signals of the
// matrix-multiply engine.
//   slave  : engine side (control/operands/read address in, status/data out)
//   master : register-file / bus side (the mirror image)
// -----------------------------------------------------------------------------
interface matmul_calc_engine_if;
    import matmul_calc_engine_pkg::*;

    logic                                  start_i;
    logic [DIM_W-1:0]                      dim_n_i;
    logic [DIM_W-1:0]                      dim_k_i;
    logic [DIM_W-1:0]                      dim_m_i;
    logic [NUM_ELEMS*DATA_WIDTH-1:0]       a_mat_i;
    logic [NUM_ELEMS*DATA_WIDTH-1:0]       b_mat_i;
    logic [SP_W-1:0]                       sp_sel_i;
    logic                                  accum_i;
    logic                                  busy_o;
    logic                                  done_o;
    logic [NUM_ELEMS-1:0]                  ovf_o;
    logic [SP_W-1:0]                       rd_sel_i;
    logic [DIM_W-1:0]                      rd_row_i;
    logic [DIM_W-1:0]                      rd_col_i;
    logic [BUS_WIDTH-1:0]                  rd_data_o;

    modport slave (
        input  start_i, dim_n_i, dim_k_i, dim_m_i, a_mat_i, b_mat_i,
               sp_sel_i, accum_i, rd_sel_i, rd_row_i, rd_col_i,
        output busy_o, done_o, ovf_o, rd_data_o
    );

    modport master (
        output start_i, dim_n_i, dim_k_i, dim_m_i, a_mat_i, b_mat_i,
               sp_sel_i, accum_i, rd_sel_i, rd_row_i, rd_col_i,
        input  busy_o, done_o, ovf_o, rd_data_o
    );
endinterface

// File: rtl/matmul_scratchpad.sv
// -----------------------------------------------------------------------------
// matmul_scratchpad
// SPNTARGETS result slots of MAX_DIM x MAX_DIM BUS_WIDTH-bit elements.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high clear of all slots
//   wr_*                    single element write port
//   seed_* / seed_data_o    combinational read used to seed accumulation
//   rd_* / rd_data_o        registered read port (returns pre-write data on a
//                           same-cycle write to the same address)
// -----------------------------------------------------------------------------
module matmul_scratchpad
    import matmul_calc_engine_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [SP_W-1:0]      wr_sel_i,
    input  logic [DIM_W-1:0]     wr_row_i,
    input  logic [DIM_W-1:0]     wr_col_i,
    input  logic [BUS_WIDTH-1:0] wr_data_i,
    input  logic [SP_W-1:0]      seed_sel_i,
    input  logic [DIM_W-1:0]     seed_row_i,
    input  logic [DIM_W-1:0]     seed_col_i,
    output logic [BUS_WIDTH-1:0] seed_data_o,
    input  logic [SP_W-1:0]      rd_sel_i,
    input  logic [DIM_W-1:0]     rd_row_i,
    input  logic [DIM_W-1:0]     rd_col_i,
    output logic [BUS_WIDTH-1:0] rd_data_o
);

    slot_t                w_slots [SPNTARGETS];
    logic [BUS_WIDTH-1:0] r_rd_data;

    // Each slot lives in its own register so only one process drives it.
    generate
        for (genvar gi = 0; gi < SPNTARGETS; gi++) begin : g_slot
            slot_t r_slot;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_slot <= '0;
                end else if (wr_en_i && (wr_sel_i == SP_W'(gi))) begin
                    r_slot[wr_row_i][wr_col_i] <= wr_data_i;
                end
            end

            assign w_slots[gi] = r_slot;
        end
    endgenerate

    assign seed_data_o = w_slots[seed_sel_i][seed_row_i][seed_col_i];

    // Reads the slot registers before this edge's write lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_slots[rd_sel_i][rd_row_i][rd_col_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/matmul_calc_engine.sv
// -----------------------------------------------------------------------------
// matmul_calc_engine
// Sequential signed matrix multiply C = A x B (or C = C + A x B) for runtime
// dimensions up to MAX_DIM, one MAC per cycle, results into a scratchpad slot.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset (aborts any calculation, clears slots)
//   bus     matmul_calc_engine_if.slave: start/dims/operands/slot/accum in,
//           busy/done/ovf out, registered result read port
// Optional feature: MATMUL_OVERFLOW_EN enables the one-bit accumulator
// extension and per-element overflow flags; without it ovf_o is 0.
// -----------------------------------------------------------------------------
module matmul_calc_engine
    import matmul_calc_engine_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    matmul_calc_engine_if.slave  bus
);

`ifdef MATMUL_OVERFLOW_EN
    localparam int ACC_W = BUS_WIDTH + 1;
`else
    localparam int ACC_W = BUS_WIDTH;
`endif

    state_t                          r_state;
    logic [DIM_W-1:0]                r_dim_n, r_dim_k, r_dim_m;
    logic [DIM_W-1:0]                r_i, r_j, r_k;
    logic [SP_W-1:0]                 r_sp_sel;
    logic                            r_accum;
    logic [NUM_ELEMS*DATA_WIDTH-1:0] r_a, r_b;
    logic signed [ACC_W-1:0]         r_acc;
    logic                            r_busy;
    logic                            r_done;

    logic signed [DATA_WIDTH-1:0]    w_a_elems [NUM_ELEMS];
    logic signed [DATA_WIDTH-1:0]    w_b_elems [NUM_ELEMS];
    logic signed [DATA_WIDTH-1:0]    w_a_cur, w_b_cur;
    logic signed [2*DATA_WIDTH-1:0]  w_prod;
    logic signed [ACC_W-1:0]         w_prod_ext, w_seed, w_base, w_sum;
    logic [BUS_WIDTH-1:0]            w_seed_rd;
    logic [BUS_WIDTH-1:0]            w_rd_data;
    logic                            w_last_k, w_last_j, w_last_i;
    logic                            w_wr_en;

    // Unpack the latched flattened operands into element arrays.
    generate
        for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_unpack
            assign w_a_elems[gi] = r_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_b_elems[gi] = r_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_a_cur    = w_a_elems[elem_idx(r_i, r_k)];
    assign w_b_cur    = w_b_elems[elem_idx(r_k, r_j)];
    assign w_prod     = w_a_cur * w_b_cur;
    assign w_prod_ext = ACC_W'(w_prod);

    // First k of an element starts from the slot contents (accumulate) or 0.
    assign w_seed = r_accum ? ACC_W'(signed'(w_seed_rd)) : '0;
    assign w_base = (r_k == '0) ? w_seed : r_acc;
    assign w_sum  = w_base + w_prod_ext;

    assign w_last_k = (r_k == r_dim_k);
    assign w_last_j = (r_j == r_dim_m);
    assign w_last_i = (r_i == r_dim_n);
    assign w_wr_en  = (r_state == ST_CALC) && w_last_k;

    matmul_scratchpad u_scratchpad (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (w_wr_en),
        .wr_sel_i    (r_sp_sel),
        .wr_row_i    (r_i),
        .wr_col_i    (r_j),
        .wr_data_i   (w_sum[BUS_WIDTH-1:0]),
        .seed_sel_i  (r_sp_sel),
        .seed_row_i  (r_i),
        .seed_col_i  (r_j),
        .seed_data_o (w_seed_rd),
        .rd_sel_i    (bus.rd_sel_i),
        .rd_row_i    (bus.rd_row_i),
        .rd_col_i    (bus.rd_col_i),
        .rd_data_o   (w_rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_dim_n  <= '0;
            r_dim_k  <= '0;
            r_dim_m  <= '0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_sp_sel <= '0;
            r_accum  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_i) begin
                        r_dim_n  <= bus.dim_n_i;
                        r_dim_k  <= bus.dim_k_i;
                        r_dim_m  <= bus.dim_m_i;
                        r_sp_sel <= bus.sp_sel_i;
                        r_accum  <= bus.accum_i;
                        r_a      <= bus.a_mat_i;
                        r_b      <= bus.b_mat_i;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    r_acc <= w_sum;
                    if (w_last_k) begin
                        r_k <= '0;
                        if (w_last_j) begin
                            r_j <= '0;
                            if (w_last_i) begin
                                r_i     <= '0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_i <= r_i + 1'b1;
                            end
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MATMUL_OVERFLOW_EN
    logic [NUM_ELEMS-1:0] r_ovf;
    logic                 w_ovf_now;

    // Extra accumulator bit disagreeing with the BUS_WIDTH sign bit means the
    // partial sum left the signed BUS_WIDTH range.
    assign w_ovf_now = (w_sum[ACC_W-1] != w_sum[ACC_W-2]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= '0;
        end else if ((r_state == ST_IDLE) && bus.start_i) begin
            r_ovf <= '0;
        end else if ((r_state == ST_CALC) && w_ovf_now) begin
            r_ovf[elem_idx(r_i, r_j)] <= 1'b1;
        end
    end

    assign bus.ovf_o = r_ovf;
`else
    assign bus.ovf_o = '0;
`endif

    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.rd_data_o = w_rd_data;

endmodule

// File: tb/tb_matmul_calc_engine.sv
module tb_matmul_calc_engine;
    import matmul_calc_engine_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    matmul_calc_engine_if bus ();

    matmul_calc_engine dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

`ifdef MATMUL_OVERFLOW_EN
    localparam logic [NUM_ELEMS-1:0] OVF_BIT0 = 4'b0001;
`else
    localparam logic [NUM_ELEMS-1:0] OVF_BIT0 = 4'b0000;
`endif

    // Elements in row-major order: e00, e01, e10, e11.
    function automatic logic [NUM_ELEMS*DATA_WIDTH-1:0] pack(input logic [31:0] e00,
            input logic [31:0] e01, input logic [31:0] e10, input logic [31:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rd_chk(input int sel, input int row, input int col, input logic [63:0] exp);
        @(negedge clk);
        bus.rd_sel_i = SP_W'(sel);
        bus.rd_row_i = DIM_W'(row);
        bus.rd_col_i = DIM_W'(col);
        @(negedge clk);
        chk($sformatf("slot%0d[%0d][%0d]", sel, row, col), bus.rd_data_o, exp);
    endtask

    task automatic drive_op(input int n, input int k, input int m,
                            input logic [NUM_ELEMS*DATA_WIDTH-1:0] a,
                            input logic [NUM_ELEMS*DATA_WIDTH-1:0] b,
                            input int sel, input bit acc);
        bus.dim_n_i  = DIM_W'(n - 1);
        bus.dim_k_i  = DIM_W'(k - 1);
        bus.dim_m_i  = DIM_W'(m - 1);
        bus.a_mat_i  = a;
        bus.b_mat_i  = b;
        bus.sp_sel_i = SP_W'(sel);
        bus.accum_i  = acc;
    endtask

    // Starts an operation and measures the busy window and done pulses.
    // With disturb set, a second start with other operands is pulsed mid-CALC.
    task automatic run_op(input int n, input int k, input int m,
                          input logic [NUM_ELEMS*DATA_WIDTH-1:0] a,
                          input logic [NUM_ELEMS*DATA_WIDTH-1:0] b,
                          input int sel, input bit acc, input bit disturb);
        int cnt, dones, guard;
        @(negedge clk);
        drive_op(n, k, m, a, b, sel, acc);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        drive_op(1, 1, 1, pack(32'd99, 32'd99, 32'd99, 32'd99),
                 pack(32'd77, 32'd77, 32'd77, 32'd77), (sel + 1) % SPNTARGETS, 1'b0);
        cnt = 0; dones = 0; guard = 0;
        @(negedge clk);
        while (bus.busy_o && guard < 600) begin
            cnt++;
            if (bus.done_o) dones++;
            if (disturb && cnt == 3) begin
                drive_op(2, 2, 2, pack(32'd9, 32'd0, 32'd0, 32'd9),
                         pack(32'd1, 32'd1, 32'd1, 32'd1), 2, 1'b0);
                bus.start_i = 1'b1;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.start_i = 1'b0;
        chk("busy_cycles", 64'(cnt), 64'(n * k * m));
        chk("done_pulse", {63'd0, bus.done_o}, 64'd1);
        if (bus.done_o) dones++;
        repeat (3) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        chk("done_count", 64'(dones), 64'd1);
    endtask

    initial begin
        logic [NUM_ELEMS*DATA_WIDTH-1:0] a1, b1, am, bm;
        a1 = pack(32'd1, 32'd2, 32'd3, 32'd4);
        b1 = pack(32'd5, 32'd6, 32'd7, 32'd8);
        am = pack(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        bm = am;
        bus.start_i = 1'b0;
        drive_op(1, 1, 1, '0, '0, 0, 1'b0);
        bus.rd_sel_i = '0;
        bus.rd_row_i = '0;
        bus.rd_col_i = '0;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("rst_done", {63'd0, bus.done_o}, 64'd0);
        chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
        chk("rst_rd_data", bus.rd_data_o, 64'd0);

        // Basic 2x2x2 into slot 0
        run_op(2, 2, 2, a1, b1, 0, 1'b0, 1'b0);
        chk("ovf_basic", 64'(bus.ovf_o), 64'd0);
        rd_chk(0, 0, 0, 64'd19);
        rd_chk(0, 0, 1, 64'd22);
        rd_chk(0, 1, 0, 64'd43);
        rd_chk(0, 1, 1, 64'd50);

        // Accumulate same operands into slot 0
        run_op(2, 2, 2, a1, b1, 0, 1'b1, 1'b0);
        rd_chk(0, 0, 0, 64'd38);
        rd_chk(0, 0, 1, 64'd44);
        rd_chk(0, 1, 0, 64'd86);
        rd_chk(0, 1, 1, 64'd100);
        for (int s = 1; s < SPNTARGETS; s++)
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    rd_chk(s, r, c, 64'd0);

        // 1x1x1: -1 * 3 into slot 3, other operand elements nonzero
        run_op(1, 1, 1, pack(32'hFFFF_FFFF, 32'd7, 32'd7, 32'd7),
               pack(32'd3, 32'd7, 32'd7, 32'd7), 3, 1'b0, 1'b0);
        rd_chk(3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        rd_chk(3, 0, 1, 64'd0);
        rd_chk(3, 1, 0, 64'd0);
        rd_chk(3, 1, 1, 64'd0);

        // 1x2x1 overflow: (-2^31)^2 * 2 = 2^63
        run_op(1, 2, 1, pack(32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0),
               pack(32'h8000_0000, 32'd0, 32'h8000_0000, 32'd0), 2, 1'b0, 1'b0);
        rd_chk(2, 0, 0, 64'h8000_0000_0000_0000);
        chk("ovf_bit0", 64'(bus.ovf_o), 64'(OVF_BIT0));

        // Reset three cycles into an 8-cycle overflowing calculation
        @(negedge clk);
        drive_op(2, 2, 2, am, bm, 1, 1'b0);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", {63'd0, bus.busy_o}, 64'd1);
        chk("mid_ovf", 64'(bus.ovf_o), 64'(OVF_BIT0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, bus.busy_o}, 64'd0);
        chk("abort_done", {63'd0, bus.done_o}, 64'd0);
        chk("abort_ovf", 64'(bus.ovf_o), 64'd0);
        for (int s = 0; s < SPNTARGETS; s++)
            for (int r = 0; r < MAX_DIM; r++)
                for (int c = 0; c < MAX_DIM; c++)
                    rd_chk(s, r, c, 64'd0);

        // Fresh start after reset; accumulate onto the cleared slot
        run_op(2, 2, 2, a1, b1, 0, 1'b1, 1'b0);
        rd_chk(0, 0, 0, 64'd19);
        rd_chk(0, 1, 1, 64'd50);

        // Second start during CALC is ignored
        run_op(2, 2, 2, a1, b1, 1, 1'b0, 1'b1);
        rd_chk(1, 0, 0, 64'd19);
        rd_chk(1, 0, 1, 64'd22);
        rd_chk(1, 1, 0, 64'd43);
        rd_chk(1, 1, 1, 64'd50);
        rd_chk(2, 0, 0, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
